// File: rtl/isr_dispatch.sv
// Job buffer in front of the integer square-root engine: FIFO intake, single-job issue
// with timeout supervision, and an ordered valid/ready result port.
module isr_dispatch #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TAG_W   = 4,
   parameter int unsigned TIMEOUT = 600
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [63:0]      in_value,
   output logic             eng_start,
   output logic             eng_abort,
   output logic [63:0]      eng_value,
   input  logic             eng_done,
   input  logic [31:0]      eng_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [TAG_W-1:0] out_tag,
   output logic [63:0]      out_value,
   output logic [31:0]      out_root,
   output logic             out_err,
   output logic             busy
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam int unsigned EW = TAG_W + 64;

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StHold} state_e;

   logic [EW-1:0]    mem [DEPTH];
   logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
   logic [CW-1:0]    count_q;
   logic [TAG_W-1:0] next_tag_q;
   state_e           state_q;
   logic [TW-1:0]    timer_q;
   logic [TAG_W-1:0] job_tag_q;
   logic [63:0]      job_value_q;
   logic [31:0]      job_root_q;
   logic             job_err_q;

   logic          full, empty, push, pop, timeout_hit;
   logic [EW-1:0] head;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign push  = in_valid && !full;
   assign pop   = (state_q == StIdle) && !empty;
   assign head  = mem[rd_ptr_q];

   // done takes priority over an expiring timer in the same cycle
   assign timeout_hit = (state_q == StWait) && !eng_done && (timer_q == TW'(TIMEOUT - 1));

   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr_q] <= {next_tag_q, in_value};
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         next_tag_q <= '0;
      end else begin
         if (push) begin
            wr_ptr_q   <= wr_ptr_q + PW'(1);
            next_tag_q <= next_tag_q + TAG_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         if (push && !pop) begin
            count_q <= count_q + CW'(1);
         end else if (!push && pop) begin
            count_q <= count_q - CW'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         timer_q     <= '0;
         job_tag_q   <= '0;
         job_value_q <= '0;
         job_root_q  <= '0;
         job_err_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (pop) begin
                  job_tag_q   <= head[EW-1:64];
                  job_value_q <= head[63:0];
                  state_q     <= StIssue;
               end
            end
            StIssue: begin
               timer_q <= '0;
               state_q <= StWait;
            end
            StWait: begin
               if (eng_done) begin
                  job_root_q <= eng_result;
                  job_err_q  <= 1'b0;
                  state_q    <= StHold;
               end else if (timeout_hit) begin
                  job_root_q <= '0;
                  job_err_q  <= 1'b1;
                  state_q    <= StHold;
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            StHold: begin
               if (out_ready) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign in_ready  = !full;
   assign eng_start = (state_q == StIssue);
   assign eng_abort = timeout_hit;
   assign eng_value = job_value_q;
   assign out_valid = (state_q == StHold);
   assign out_tag   = job_tag_q;
   assign out_value = job_value_q;
   assign out_root  = job_root_q;
   assign out_err   = job_err_q;
   assign busy      = (state_q != StIdle) || !empty;

endmodule
